// File: rtl/text_mem_arbiter_pkg.sv
// Shared types and dimensions for the 40x15 character RAM arbiter.
// Holds the screen geometry, bus widths and the clear-engine state encoding.
package text_mem_pkg;

  localparam int COLS       = 40;
  localparam int ROWS       = 15;
  localparam int CELLS      = COLS * ROWS;
  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 10;
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] char_t;

  typedef enum logic {IDLE, CLEAR} clr_state_t;

  typedef struct packed {
    addr_t addr;
    char_t data;
  } wr_entry_t;

  localparam addr_t                 CELLS_A   = addr_t'(CELLS);
  localparam addr_t                 LAST_ADDR = addr_t'(CELLS - 1);
  localparam logic [FIFO_CNT_W-1:0] FIFO_FULL = FIFO_CNT_W'(FIFO_DEPTH);

endpackage

// File: rtl/text_mem_arbiter_if.sv
// Bundle of keyboard, clear, video and RAM-side signals around the arbiter.
// The arbiter takes the slave view; the surrounding system drives the master view.
interface text_mem_arbiter_if;
  import text_mem_pkg::*;

  logic  wr_en;
  addr_t wr_addr;
  char_t wr_data;
  logic  wr_full;
  logic  clr_req;
  logic  clr_busy;
  logic  vid_req;
  addr_t vid_addr;
  logic  vid_valid;
  char_t vid_rdata;
  addr_t mem_addr;
  logic  mem_we;
  char_t mem_wdata;
  char_t mem_rdata;
  logic  err;

  modport slave (
    input  wr_en, wr_addr, wr_data, clr_req, vid_req, vid_addr, mem_rdata,
    output wr_full, clr_busy, vid_valid, vid_rdata, mem_addr, mem_we, mem_wdata, err
  );

  modport master (
    output wr_en, wr_addr, wr_data, clr_req, vid_req, vid_addr, mem_rdata,
    input  wr_full, clr_busy, vid_valid, vid_rdata, mem_addr, mem_we, mem_wdata, err
  );

endinterface

// File: rtl/text_mem_arbiter_wr_fifo.sv
// Small synchronous FIFO buffering keyboard writes while the RAM is busy.
// Flush wins over push and pop; a push into a full FIFO needs a same-cycle pop.
module wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int              PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W:0]   r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == FULL_CNT);
  assign o_count  = r_count;
  assign o_data   = r_mem[r_rdPtr];
  assign w_doPop  = i_pop && !o_empty && !i_flush;
  assign w_doPush = i_push && !i_flush && (!o_full || w_doPop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      r_count <= r_count + {{PTR_W{1'b0}}, w_doPush} - {{PTR_W{1'b0}}, w_doPop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_data;
  end

endmodule

// File: rtl/text_mem_arbiter.sv
// Shares the single-port character RAM between video reads, the clear sweep and
// buffered keyboard writes, in that priority order.
module text_mem_arbiter
  import text_mem_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  text_mem_arbiter_if.slave  bus
);

  clr_state_t                r_state;
  clr_state_t                w_stateNext;
  addr_t                     r_clrCnt;
  addr_t                     w_clrCntNext;
  logic                      r_vidValid;
  logic                      r_err;
  logic                      w_clrStart;
  logic                      w_addrOk;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_drop;
  wr_entry_t                 w_fifoIn;
  wr_entry_t                 w_fifoHead;
  logic                      w_fifoFull;
  logic                      w_fifoEmpty;
  logic [FIFO_CNT_W-1:0]     w_fifoCount;

  assign w_clrStart = (r_state == IDLE) && bus.clr_req;
  assign w_addrOk   = (bus.wr_addr < CELLS_A);
  assign w_fifoIn   = '{addr: bus.wr_addr, data: bus.wr_data};

  // A write arriving with the clear request is discarded along with the flush.
  assign w_push = bus.wr_en && !w_clrStart && w_addrOk && (!w_fifoFull || w_pop);
  assign w_drop = bus.wr_en && !w_clrStart && (!w_addrOk || (w_fifoFull && !w_pop));

  wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_wrFifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_clrStart),
    .i_data  (w_fifoIn),
    .o_data  (w_fifoHead),
    .o_full  (w_fifoFull),
    .o_empty (w_fifoEmpty),
    .o_count (w_fifoCount)
  );

  // Grant mux and clear sequencing; reset forces the RAM pins quiet at once.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    w_pop         = 1'b0;
    w_stateNext   = r_state;
    w_clrCntNext  = r_clrCnt;
    if (rst) begin
      w_stateNext  = IDLE;
      w_clrCntNext = '0;
    end else if (bus.vid_req) begin
      bus.mem_addr = bus.vid_addr;
    end else if (r_state == CLEAR) begin
      bus.mem_we   = 1'b1;
      bus.mem_addr = r_clrCnt;
      if (r_clrCnt == LAST_ADDR) begin
        w_stateNext  = IDLE;
        w_clrCntNext = '0;
      end else begin
        w_clrCntNext = r_clrCnt + 1'b1;
      end
    end else if (!w_fifoEmpty && !w_clrStart) begin
      w_pop         = 1'b1;
      bus.mem_we    = 1'b1;
      bus.mem_addr  = w_fifoHead.addr;
      bus.mem_wdata = w_fifoHead.data;
    end
    if (!rst && w_clrStart) begin
      w_stateNext  = CLEAR;
      w_clrCntNext = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_clrCnt   <= '0;
      r_vidValid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_clrCnt   <= w_clrCntNext;
      r_vidValid <= bus.vid_req;
      r_err      <= r_err | w_drop;
    end
  end

  assign bus.vid_valid = r_vidValid;
  assign bus.vid_rdata = r_vidValid ? bus.mem_rdata : '0;
  assign bus.clr_busy  = (r_state == CLEAR);
  assign bus.wr_full   = (w_fifoCount == FIFO_FULL);
  assign bus.err       = r_err;

endmodule

// File: tb/tb_text_mem_arbiter.sv
// Self-checking bench for text_mem_arbiter: vector table, corner sequences and
// randomized traffic against a queue-based reference of the arbitration rules.
module tb_text_mem_arbiter;
  import text_mem_pkg::*;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  typedef struct {
    bit we; int wa; int wd; bit vr; int va; bit cr;
    bit eWe; int eAddr; int eData; bit eErr; bit eVv; int eVd;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  text_mem_arbiter_if bus();

  text_mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural single-port RAM with one-cycle read latency.
  char_t ram [1024] = '{default: '0};
  always @(posedge clk) begin
    bus.mem_rdata <= ram[bus.mem_addr];
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
  end

  // Reference state: pending keyboard writes, clear progress, RAM shadow.
  wr_t mq[$];
  wr_t wlog[$];
  bit  mClearing;
  int  mClrIdx;
  bit  mErr;
  bit  mVidPrev;
  int  mVidData;
  int  shadow [1024] = '{default: 0};
  int  checks = 0;
  int  errors = 0;
  int  busySeen = 0;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit we, input int wa, input int wd,
                               input bit vr, input int va, input bit cr);
    bus.wr_en    = we;
    bus.wr_addr  = addr_t'(wa);
    bus.wr_data  = char_t'(wd);
    bus.vid_req  = vr;
    bus.vid_addr = addr_t'(va);
    bus.clr_req  = cr;
  endtask

  task automatic modelReset();
    mq.delete();
    mClearing = 0;
    mClrIdx   = 0;
    mErr      = 0;
    mVidPrev  = 0;
    mVidData  = 0;
  endtask

  // Evaluate one cycle of the reference, optionally compare, then advance it.
  task automatic modelStep(input bit doCheck);
    bit clrStart, pop, wasFull;
    int eWe, eAddr, eData, vidData;
    clrStart = !mClearing && bus.clr_req;
    pop = 0; eWe = 0; eAddr = 0; eData = 0;
    if (bus.vid_req) begin
      eAddr = int'(bus.vid_addr);
    end else if (mClearing) begin
      eWe = 1; eAddr = mClrIdx;
    end else if (!clrStart && mq.size() > 0) begin
      eWe = 1; eAddr = mq[0].addr; eData = mq[0].data; pop = 1;
    end
    if (doCheck) begin
      checkOutput("mem_we", int'(bus.mem_we), eWe);
      checkOutput("mem_addr", int'(bus.mem_addr), eAddr);
      checkOutput("mem_wdata", int'(bus.mem_wdata), eData);
      checkOutput("wr_full", int'(bus.wr_full), int'(mq.size() == FIFO_DEPTH));
      checkOutput("clr_busy", int'(bus.clr_busy), int'(mClearing));
      checkOutput("err", int'(bus.err), int'(mErr));
      checkOutput("vid_valid", int'(bus.vid_valid), int'(mVidPrev));
      checkOutput("vid_rdata", int'(bus.vid_rdata), mVidPrev ? mVidData : 0);
      if (bus.clr_busy) busySeen++;
    end
    if (bus.mem_we) wlog.push_back('{int'(bus.mem_addr), int'(bus.mem_wdata)});
    vidData = bus.vid_req ? shadow[int'(bus.vid_addr)] : 0;
    wasFull = (mq.size() == FIFO_DEPTH);
    if (eWe) shadow[eAddr] = eData;
    if (pop) void'(mq.pop_front());
    if (clrStart) begin
      mq.delete();
      mClearing = 1;
      mClrIdx = 0;
    end else begin
      if (mClearing && !bus.vid_req) begin
        if (mClrIdx == CELLS - 1) begin
          mClearing = 0;
          mClrIdx = 0;
        end else begin
          mClrIdx++;
        end
      end
      if (bus.wr_en) begin
        if (int'(bus.wr_addr) >= CELLS) mErr = 1;
        else if (wasFull && !pop) mErr = 1;
        else mq.push_back('{int'(bus.wr_addr), int'(bus.wr_data)});
      end
    end
    mVidData = vidData;
    mVidPrev = bus.vid_req;
  endtask

  task automatic step(input bit we, input int wa, input int wd,
                      input bit vr, input int va, input bit cr);
    applyStimulus(we, wa, wd, vr, va, cr);
    @(negedge clk);
    modelStep(1);
    @(posedge clk);
    #1;
  endtask

  // Reset must silence the RAM pins and flags without waiting for a clock.
  task automatic doReset();
    rst = 1'b1;
    #1;
    checkOutput("rst mem_we", int'(bus.mem_we), 0);
    checkOutput("rst mem_addr", int'(bus.mem_addr), 0);
    checkOutput("rst clr_busy", int'(bus.clr_busy), 0);
    checkOutput("rst err", int'(bus.err), 0);
    checkOutput("rst wr_full", int'(bus.wr_full), 0);
    checkOutput("rst vid_valid", int'(bus.vid_valid), 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    int bad, idx599;
    int seen [CELLS];

    applyStimulus(0, 0, 0, 0, 0, 0);
    #2;
    doReset();

    // Vector table: basic write, video read-back, bad address, sticky err.
    vecs.push_back('{1, 41, 5, 0, 0, 0,   0, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0,    1, 41, 5, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 1, 41, 0,   0, 41, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 1, 5});
    vecs.push_back('{1, 600, 3, 0, 0, 0,  0, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0,    0, 0, 0, 1, 0, 0});
    vecs.push_back('{1, 599, 1, 1, 599, 0, 0, 599, 0, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0,    1, 599, 1, 1, 1, 0});
    vecs.push_back('{0, 0, 0, 1, 599, 0,  0, 599, 0, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0,    0, 0, 0, 1, 1, 1});
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].vr, vecs[i].va, vecs[i].cr);
      @(negedge clk);
      checkOutput($sformatf("vec%0d mem_we", i), int'(bus.mem_we), int'(vecs[i].eWe));
      checkOutput($sformatf("vec%0d mem_addr", i), int'(bus.mem_addr), vecs[i].eAddr);
      checkOutput($sformatf("vec%0d mem_wdata", i), int'(bus.mem_wdata), vecs[i].eData);
      checkOutput($sformatf("vec%0d err", i), int'(bus.err), int'(vecs[i].eErr));
      checkOutput($sformatf("vec%0d vid_valid", i), int'(bus.vid_valid), int'(vecs[i].eVv));
      checkOutput($sformatf("vec%0d vid_rdata", i), int'(bus.vid_rdata), vecs[i].eVd);
      modelStep(0);
      @(posedge clk);
      #1;
    end

    // Video priority: writes queue behind a 10-cycle read burst, then drain in order.
    doReset();
    wlog.delete();
    for (int i = 0; i < 10; i++) step(i < 3, i, 20 + i, 1, 100 + i, 0);
    checkOutput("writes during video", wlog.size(), 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
    checkOutput("drain count", wlog.size(), 3);
    for (int i = 0; i < 3 && i < wlog.size(); i++) begin
      checkOutput("drain addr", wlog[i].addr, i);
      checkOutput("drain data", wlog[i].data, 20 + i);
    end

    // Overflow: fifth push while video holds the RAM is lost.
    doReset();
    for (int i = 0; i < 5; i++) step(1, 10 + i, i, 1, 0, 0);
    checkOutput("overflow wr_full", int'(bus.wr_full), 1);
    checkOutput("overflow err", int'(bus.err), 1);
    wlog.delete();
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0);
    checkOutput("overflow drain count", wlog.size(), 4);
    for (int i = 0; i < 4 && i < wlog.size(); i++)
      checkOutput("overflow drain addr", wlog[i].addr, 10 + i);

    // Clear sweep with a flushed FIFO and an ignored mid-sweep clr_req.
    doReset();
    step(1, 50, 1, 1, 0, 0);
    step(1, 51, 2, 1, 0, 0);
    step(0, 0, 0, 1, 0, 1);
    wlog.delete();
    busySeen = 0;
    for (int n = 0; n < 620; n++) step(0, 0, 0, 0, 0, mClearing && mClrIdx == 300);
    checkOutput("sweep write count", wlog.size(), CELLS);
    bad = 0;
    foreach (wlog[i]) if (wlog[i].addr != i || wlog[i].data != 0) bad++;
    checkOutput("sweep order", bad, 0);
    checkOutput("sweep busy cycles", busySeen, CELLS);

    // Clear stalled by 50% video, with a keyboard write landing mid-sweep.
    doReset();
    step(0, 0, 0, 0, 0, 1);
    wlog.delete();
    for (int n = 0; n < 1400; n++) step(n == 200, 7, 9, n % 2 == 1, n % CELLS, 0);
    checkOutput("stalled write count", wlog.size(), CELLS + 1);
    foreach (seen[a]) seen[a] = 0;
    idx599 = -1;
    foreach (wlog[i]) begin
      if (wlog[i].data == 0 && wlog[i].addr < CELLS) seen[wlog[i].addr]++;
      if (wlog[i].data == 0 && wlog[i].addr == CELLS - 1) idx599 = i;
    end
    bad = 0;
    foreach (seen[a]) if (seen[a] != 1) bad++;
    checkOutput("stalled coverage", bad, 0);
    checkOutput("late write follows sweep",
                (idx599 >= 0 && idx599 + 1 < wlog.size() &&
                 wlog[idx599 + 1].addr == 7 && wlog[idx599 + 1].data == 9) ? 1 : 0, 1);

    // Reset in the middle of a sweep with writes pending.
    doReset();
    step(1, 700, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    for (int n = 0; n < 50; n++) step(n < 3, n + 1, 4, 0, 0, 0);
    doReset();
    wlog.delete();
    for (int n = 0; n < 5; n++) step(0, 0, 0, 0, 0, 0);
    checkOutput("post-reset writes", wlog.size(), 0);

    // Randomized traffic against the reference.
    doReset();
    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 1) == 1,
           ($urandom_range(0, 15) == 0) ? int'($urandom_range(600, 1023)) : int'($urandom_range(0, 599)),
           int'($urandom_range(0, 1023)),
           $urandom_range(0, 9) < 4,
           int'($urandom_range(0, 599)),
           $urandom_range(0, 299) == 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_mem_arbiter.md
Name: text_mem_arbiter

Overview:
- Owns the single-port 40x15 character RAM (600 cells, 10-bit address, 10-bit code) and shares it between three requesters.
- Requesters, in priority order: the VGA character fetch (read), an internal screen-clear engine, and the keyboard writer.
- Keyboard writes are buffered in a small FIFO so none are lost while video or clear holds the RAM; the block sits between the keyboard write path and the RAM.

Parameters:
- COLS, 40, characters per line
- ROWS, 15, lines per screen
- CELLS, COLS*ROWS (600), valid address range 0..CELLS-1
- ADDR_W, 10, RAM address width
- DATA_W, 10, character code width
- FIFO_DEPTH, 4, keyboard write buffer entries (power of two)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  keyboard write strobe, one cycle per character
- wr_addr  in  ADDR_W  keyboard write address
- wr_data  in  DATA_W  keyboard write code
- wr_full  out  1  FIFO full; a wr_en in this cycle is dropped
- clr_req  in  1  clear-screen request pulse
- clr_busy  out  1  clear sweep in progress
- vid_req  in  1  video read request (highest priority)
- vid_addr  in  ADDR_W  video read address
- vid_valid  out  1  read data valid
- vid_rdata  out  DATA_W  read data
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after address
- err  out  1  sticky: dropped write (FIFO overflow or address >= CELLS)

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE, clear counter 0, err 0.
- Per-cycle grant, exactly one of:
  - vid_req: mem_addr = vid_addr, mem_we = 0.
  - Else if state CLEAR: write 0 to clear counter address.
  - Else if FIFO not empty: pop head and write it.
  - Else: idle, mem_we = 0, mem_addr = 0.
- Port outputs are combinational from the grant; no registers between the grant and the RAM pins.
- Video read latency:
  - vid_valid is vid_req registered one cycle.
  - vid_rdata = mem_rdata in the cycle vid_valid is high.
  - A continuous vid_req stream gives continuous vid_valid.
- Keyboard FIFO:
  - Push on wr_en when not full and wr_addr < CELLS.
  - wr_en while full drops the write and sets err.
  - wr_addr >= CELLS drops the write and sets err.
  - Push and pop in the same cycle are both honoured; a push while full is allowed only if a pop occurs in the same cycle.
  - wr_full is combinational from the occupancy count.
  - Write order to RAM equals arrival order.
- Clear FSM, two states:
  - IDLE -> CLEAR on clr_req: counter <= 0, FIFO flushed in the same cycle; a wr_en in that same cycle is discarded.
  - CLEAR: counter advances only in cycles where clear owns the grant, so video stalls it.
  - Exit after writing address CELLS-1: counter returns to 0, state returns to IDLE.
  - clr_req during CLEAR is ignored; the sweep does not restart.
  - wr_en during CLEAR pushes normally; these writes drain after the clear completes.
  - clr_busy = (state == CLEAR).
- err clears only on rst.
- Reset mid-clear or mid-drain aborts immediately: FIFO emptied, no partial write completes after rst rises.
- Widths:
  - Counter is ADDR_W bits and compares against CELLS-1.
  - No arithmetic wrap is relied upon.

Decomposition:
- Package text_mem_pkg: COLS, ROWS, CELLS, ADDR_W, DATA_W, typedef addr_t, typedef char_t, enum clr_state_t {IDLE, CLEAR}.
- Sub-module wr_fifo: synchronous FIFO with push/pop/flush, full, empty and count, parameterised on FIFO_DEPTH and entry width ADDR_W+DATA_W.
- Grant mux and clear FSM stay in text_mem_arbiter.

Test Plan:
- Basic write: wr_en addr 41 data 5, no vid_req -> next cycle mem_we=1, mem_addr=41, mem_wdata=5; err stays 0.
- Video priority: vid_req held 10 cycles while 3 writes (addr 0,1,2) are pushed -> no mem_we during vid_req; vid_valid tracks vid_req delayed by 1; the 3 writes emerge in order on the 3 cycles after vid_req drops.
- Overflow: vid_req held, 5 wr_en pulses -> wr_full after 4th push, 5th dropped, err=1; after release exactly 4 RAM writes occur.
- Clear sweep:
  - Stimulus: clr_req with 2 entries queued and no video.
  - Required: FIFO flushed; 600 consecutive writes of 0 to addresses 0..599; clr_busy high exactly 600 cycles.
  - Required: clr_req pulsed at sweep address 300 has no effect.
- Clear stalled by video plus late writes:
  - Stimulus: vid_req 50% duty during clear; wr_en addr 7 data 9 mid-sweep.
  - Required: every address 0..599 still written once; addr 7 written with 9 after the write of address 599.
- Bad address and reset: wr_en addr 600 -> no RAM write, err=1; rst asserted mid-clear -> clr_busy, mem_we, err all 0 immediately, FIFO empty.
